// File: rtl/mdu_seq_pkg.sv
// Shared constants and types for the sequential multiply/divide unit.
// Also holds the ALU control codes that mdu_seq drives onto the shared ALU.
package mdu_seq_pkg;

  localparam int ITER = 32;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

endpackage

// File: rtl/mdu_seq_if.sv
// Request/result bus of mdu_seq plus its port onto the shared add/sub ALU.
// The master side is the requester, which also provides the ALU result.
interface mdu_seq_if;

  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_r;

  modport master (
    output start, op, a, b, alu_r,
    input  busy, done, div0, hi, lo, alu_x, alu_y, alu_aluc
  );

  modport slave (
    input  start, op, a, b, alu_r,
    output busy, done, div0, hi, lo, alu_x, alu_y, alu_aluc
  );

endinterface

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide on the {hi, lo} pair.
// Drives the shared ALU operands and folds the ALU result back in the same cycle.
module mdu_step
  import mdu_seq_pkg::*;
(
  input  logic        en,
  input  op_t         op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] operand,
  input  logic [31:0] alu_r,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [3:0]  alu_aluc,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);

  logic [31:0] shifted;
  logic        carry;

  // Partial remainder shifted left by one; hi[31] is its dropped 33rd bit.
  assign shifted = {hi[30:0], lo[31]};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    alu_x    = '0;
    alu_y    = '0;
    alu_aluc = ALUC_ADD;
    hi_nxt   = hi;
    lo_nxt   = lo;
    carry    = 1'b0;
    if (en) begin
      if (op == OP_MUL) begin
        alu_x    = hi;
        alu_y    = lo[0] ? operand : 32'd0;
        alu_aluc = ALUC_ADD;
        // An unsigned add wrapped iff the sum came out below one of its addends.
        carry    = (alu_r < hi);
        hi_nxt   = {carry, alu_r[31:1]};
        lo_nxt   = {alu_r[0], lo[31:1]};
      end else begin
        alu_x    = shifted;
        alu_y    = operand;
        alu_aluc = ALUC_SUB;
        if (hi[31] || (shifted >= operand)) begin
          hi_nxt = alu_r;
          lo_nxt = {lo[30:0], 1'b1};
        end else begin
          hi_nxt = shifted;
          lo_nxt = {lo[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential unsigned multiply/divide: IDLE -> RUN (ITER steps) -> DONE.
// Arithmetic goes through an external shared ALU, one operation per RUN cycle.
module mdu_seq
  import mdu_seq_pkg::state_t, mdu_seq_pkg::op_t, mdu_seq_pkg::ST_IDLE,
         mdu_seq_pkg::ST_RUN, mdu_seq_pkg::ST_DONE, mdu_seq_pkg::OP_MUL,
         mdu_seq_pkg::OP_DIV;
#(
  parameter int ITER = mdu_seq_pkg::ITER
) (
  input  logic       clk,
  input  logic       clrn,
  mdu_seq_if.slave   bus
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] opnd_q;
  logic [31:0] hi_q, lo_q;
  logic        div0_q;
  op_t         op_q;

  logic        accept, req_div0, last_iter;
  logic        run_en, busy, done;
  logic [31:0] hi_nxt, lo_nxt;

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign req_div0  = (op_t'(bus.op) == OP_DIV) && (bus.b == 32'd0);
  assign last_iter = (cnt_q == 5'(ITER - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = req_div0 ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == ST_RUN);
    done   = (state_q == ST_DONE);
    run_en = busy;
  end

  mdu_step u_step (
    .en       (run_en),
    .op       (op_q),
    .hi       (hi_q),
    .lo       (lo_q),
    .operand  (opnd_q),
    .alu_r    (bus.alu_r),
    .alu_x    (bus.alu_x),
    .alu_y    (bus.alu_y),
    .alu_aluc (bus.alu_aluc),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      div0_q <= 1'b0;
      op_q   <= OP_MUL;
    end else if (accept) begin
      cnt_q  <= '0;
      opnd_q <= bus.b;
      op_q   <= op_t'(bus.op);
      div0_q <= req_div0;
      // Divide by zero skips RUN: quotient saturates, remainder is the dividend.
      hi_q   <= req_div0 ? bus.a : 32'd0;
      lo_q   <= req_div0 ? 32'hFFFF_FFFF : bus.a;
    end else if (run_en) begin
      cnt_q  <= cnt_q + 5'd1;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter ITER, default 32, number of iterations per operation (equals operand width).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  1  0 = unsigned multiply, 1 = unsigned divide; sampled with start.
REQ-006 a  input  32  multiplicand or dividend; sampled with start.
REQ-007 b  input  32  multiplier or divisor; sampled with start.
REQ-008 busy  output  1  high in RUN.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 div0  output  1  set when a divide with b==0 was accepted; held until the next accepted start.
REQ-011 hi  output  32  product[63:32] or remainder.
REQ-012 lo  output  32  product[31:0] or quotient.
REQ-013 alu_x  output  32  X operand to the shared ALU.
REQ-014 alu_y  output  32  Y operand to the shared ALU.
REQ-015 alu_aluc  output  4  ALU control; only 4'b0000 (add) and 4'b0100 (sub) are issued.
REQ-016 alu_r  input  32  combinational ALU result for the current alu_x, alu_y and alu_aluc.

Function
REQ-017 States: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after ITER iterations; DONE->IDLE unconditionally.
REQ-018 Divide with b==0 goes IDLE->DONE directly: lo=32'hFFFFFFFF, hi=a, div0=1; no ALU ops are issued.
REQ-019 On accept: latch b into an operand register and clear the 5-bit iteration counter. Multiply: hi=0, lo=a. Divide: hi=0, lo=a.
REQ-020 RUN issues exactly one ALU operation per cycle and consumes alu_r in the same cycle; the counter increments each RUN cycle; RUN exits after the cycle with count==ITER-1.
REQ-021 Multiply step: alu_x=hi; alu_y = lo[0] ? operand : 0; aluc=add; c = (alu_r < hi) unsigned; next hi={c, alu_r[31:1]}; next lo={alu_r[0], lo[31:1]}.
REQ-022 Divide step: s={hi[30:0], lo[31]}; alu_x=s; alu_y=operand; aluc=sub. If hi[31]==1 or s>=operand (unsigned): next hi=alu_r and next lo={lo[30:0],1}. Otherwise next hi=s and next lo={lo[30:0],0}.
REQ-023 Outside RUN: alu_x=0, alu_y=0, alu_aluc=4'b0000.
REQ-024 Latency: start accepted at edge k; busy is high for cycles k+1..k+ITER; done is high in cycle k+ITER+1. For divide-by-zero, done is high in cycle k+1.
REQ-025 start is ignored in RUN and DONE; there is no queueing.
REQ-026 hi, lo and div0 hold their last values in IDLE until the next accepted start.
REQ-027 start may be asserted in the same cycle the block returns to IDLE (cycle after done); back-to-back operations are allowed.

Reset
REQ-028 clrn low forces state=IDLE, counter=0, hi=0, lo=0, div0=0, busy=0, done=0, alu_x=0, alu_y=0, alu_aluc=0, regardless of clk.
REQ-029 Reset during RUN abandons the operation; no done pulse is produced.
REQ-030 The first start after clrn deasserts behaves as from a cold reset.

Structure
REQ-031 A shared package holds the ALU control constants (ALUC_ADD=4'b0000, ALUC_SUB=4'b0100), the state encoding and ITER.
REQ-032 A combinational sub-module mdu_step computes alu_x, alu_y, alu_aluc and next hi/lo from op, hi, lo, operand and alu_r. mdu_seq holds the FSM, counter and registers.
REQ-033 The bench ties alu_* to the team ALU (add/sub path).

Verification
REQ-034 op=0, a=3, b=5 -> busy 32 cycles; done at k+33; hi=0, lo=15.
REQ-035 op=0, a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-036 op=1, a=100, b=7 -> lo=14, hi=2, div0=0. op=1, a=32'hFFFFFFFF, b=1 -> lo=32'hFFFFFFFF, hi=0.
REQ-037 op=1, a=42, b=0 -> done at k+1; lo=32'hFFFFFFFF, hi=42, div0=1; alu_aluc stays 0.
REQ-038 start pulsed at count 10 of a running op -> ignored; result unchanged. clrn pulsed at count 20 -> all outputs 0 immediately; no done pulse.
REQ-039 Two back-to-back ops (6*7, then 50/8) -> 42, then q=6, r=2, with correct done spacing.
